// File: rtl/fp_pkg.sv
// Shared FP datapath definitions: field slices, constants, and
// the float-to-int converter state encoding.
package fp_pkg;

    localparam int FP_BIAS = 127;
    localparam logic [7:0] FP_EXP_SPECIAL = 8'hFF;
    localparam logic [7:0] FP_EXP_INT_LIM = 8'd158;
    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    localparam int S_BIT = 31;
    localparam int E_MSB = 30;
    localparam int E_LSB = 23;
    localparam int M_MSB = 22;
    localparam int M_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SIGN
    } f2i_state_t;

endpackage

// File: rtl/float_to_signed_int.sv
// Single-precision float to int32 converter, truncating and saturating.
// Uses an iterative right shifter instead of a full barrel shifter.
module float_to_signed_int
    import fp_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] FP_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] signed_int_val,
    output logic        ovfl,
    output logic        invalid
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    f2i_state_t  state_q, state_d;
    logic        sign_q, sign_d;
    logic        sat_q, sat_d;
    logic        ovfl_p_q, ovfl_p_d;
    logic        inv_p_q, inv_p_d;
    logic [31:0] mag_q, mag_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_d;
    logic        ovfl_d;
    logic        inv_d;
    logic [31:0] res_d;

    logic        op_s;
    logic [7:0]  op_e;
    logic [22:0] op_m;
    logic [4:0]  amt;

    assign op_s = FP_val[S_BIT];
    assign op_e = FP_val[E_MSB:E_LSB];
    assign op_m = FP_val[M_MSB:M_LSB];
    assign amt  = (cnt_q < STEP) ? cnt_q : STEP;
    assign busy = (state_q != IDLE);

    // Next-state, datapath and output computation.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        sat_d    = sat_q;
        ovfl_p_d = ovfl_p_q;
        inv_p_d  = inv_p_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        res_d    = signed_int_val;
        ovfl_d   = ovfl;
        inv_d    = invalid;
        unique case (state_q)
            IDLE: begin
                // done blocks acceptance so back-to-back starts are spaced
                if (start && !done) begin
                    sign_d   = op_s;
                    sat_d    = 1'b0;
                    ovfl_p_d = 1'b0;
                    inv_p_d  = 1'b0;
                    mag_d    = '0;
                    cnt_d    = '0;
                    state_d  = SIGN;
                    if (op_e == FP_EXP_SPECIAL) begin
                        if (op_m != '0) begin
                            inv_p_d = 1'b1;
                        end else begin
                            sat_d    = 1'b1;
                            mag_d    = op_s ? INT_MIN : INT_MAX;
                            ovfl_p_d = 1'b1;
                        end
                    end else if (op_e >= FP_EXP_INT_LIM) begin
                        sat_d    = 1'b1;
                        mag_d    = op_s ? INT_MIN : INT_MAX;
                        ovfl_p_d = !(op_s && op_e == FP_EXP_INT_LIM
                                     && op_m == '0);
                    end else if (op_e >= 8'(FP_BIAS)) begin
                        mag_d   = {1'b1, op_m, 8'b0};
                        cnt_d   = 5'(FP_EXP_INT_LIM - op_e);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mag_d = mag_q >> amt;
                cnt_d = cnt_q - amt;
                if (cnt_q == amt) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                res_d   = (sign_q && !sat_q) ? -mag_q : mag_q;
                ovfl_d  = ovfl_p_q;
                inv_d   = inv_p_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sign_q         <= 1'b0;
            sat_q          <= 1'b0;
            ovfl_p_q       <= 1'b0;
            inv_p_q        <= 1'b0;
            mag_q          <= '0;
            cnt_q          <= '0;
            done           <= 1'b0;
            signed_int_val <= '0;
            ovfl           <= 1'b0;
            invalid        <= 1'b0;
        end else begin
            state_q        <= state_d;
            sign_q         <= sign_d;
            sat_q          <= sat_d;
            ovfl_p_q       <= ovfl_p_d;
            inv_p_q        <= inv_p_d;
            mag_q          <= mag_d;
            cnt_q          <= cnt_d;
            done           <= done_d;
            signed_int_val <= res_d;
            ovfl           <= ovfl_d;
            invalid        <= inv_d;
        end
    end

endmodule

// File: tb/tb_float_to_signed_int.sv
// Directed-vector bench for float_to_signed_int, covering
// SHIFT_STEP=1 and SHIFT_STEP=4 instances.
module tb_float_to_signed_int;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic [31:0] fp1 = '0;
    logic [31:0] fp4 = '0;
    logic        busy1, done1, ovfl1, inv1;
    logic        busy4, done4, ovfl4, inv4;
    logic [31:0] res1, res4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    float_to_signed_int #(.SHIFT_STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .FP_val(fp1),
        .busy(busy1), .done(done1), .signed_int_val(res1),
        .ovfl(ovfl1), .invalid(inv1)
    );

    float_to_signed_int #(.SHIFT_STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .FP_val(fp4),
        .busy(busy4), .done(done4), .signed_int_val(res4),
        .ovfl(ovfl4), .invalid(inv4)
    );

    typedef struct {
        bit          use4;
        logic [31:0] fp;
        logic [31:0] exp;
        bit          eovfl;
        bit          einv;
        int          elat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One conversion; optionally re-pulses start while busy.
    task automatic conv(input bit use4, input logic [31:0] v,
                        input bit repulse,
                        output logic [31:0] r, output bit o,
                        output bit iv, output int lat,
                        output bit busy_seen, output int ndone);
        int n;
        bit d;
        @(negedge clk);
        if (use4) begin start4 = 1'b1; fp4 = v; end
        else begin start1 = 1'b1; fp1 = v; end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        busy_seen = use4 ? busy4 : busy1;
        n = 1;
        d = use4 ? done4 : done1;
        if (repulse && !d) begin
            if (use4) start4 = 1'b1; else start1 = 1'b1;
        end
        while (!d && n < 100) begin
            @(posedge clk);
            #1;
            start1 = 1'b0;
            start4 = 1'b0;
            n++;
            d = use4 ? done4 : done1;
        end
        lat = d ? n : -1;
        ndone = d ? 1 : 0;
        r = use4 ? res4 : res1;
        o = use4 ? ovfl4 : ovfl1;
        iv = use4 ? inv4 : inv1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (use4 ? done4 : done1) ndone++;
        end
    endtask

    initial begin
        logic [31:0] r;
        bit o, iv, bs;
        int lat, nd;

        vecs.push_back('{0, 32'h3F80_0000, 32'h0000_0001, 0, 0, 33});
        vecs.push_back('{0, 32'hC2F6_E979, 32'hFFFF_FF85, 0, 0, 27});
        vecs.push_back('{0, 32'h4F00_0000, 32'h7FFF_FFFF, 1, 0, 2});
        vecs.push_back('{0, 32'hCF00_0000, 32'h8000_0000, 0, 0, 2});
        vecs.push_back('{0, 32'hFF80_0000, 32'h8000_0000, 1, 0, 2});
        vecs.push_back('{0, 32'h7FC0_0000, 32'h0000_0000, 0, 1, 2});
        vecs.push_back('{0, 32'h3F00_0000, 32'h0000_0000, 0, 0, 2});
        vecs.push_back('{0, 32'h8000_0000, 32'h0000_0000, 0, 0, 2});
        vecs.push_back('{0, 32'h7F80_0000, 32'h7FFF_FFFF, 1, 0, 2});
        vecs.push_back('{0, 32'hCF00_0001, 32'h8000_0000, 1, 0, 2});
        vecs.push_back('{0, 32'h4020_0000, 32'h0000_0002, 0, 0, 32});
        vecs.push_back('{0, 32'hC020_0000, 32'hFFFF_FFFE, 0, 0, 32});
        vecs.push_back('{0, 32'h3F7F_FFFF, 32'h0000_0000, 0, 0, 2});
        vecs.push_back('{0, 32'hCEFF_FFFF, 32'h8000_0080, 0, 0, 3});
        vecs.push_back('{1, 32'h4EFF_FFFF, 32'h7FFF_FF80, 0, 0, 3});
        vecs.push_back('{1, 32'h3F80_0000, 32'h0000_0001, 0, 0, 10});
        vecs.push_back('{1, 32'hC2F6_E979, 32'hFFFF_FF85, 0, 0, 9});

        #12;
        chk("reset_outputs1",
            {31'b0, busy1, done1, ovfl1, inv1, res1[27:0]}, '0);
        chk("reset_res1", res1, 32'h0);
        chk("reset_outputs4", {28'b0, busy4, done4, ovfl4, inv4}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            conv(vecs[i].use4, vecs[i].fp, 1'b0, r, o, iv, lat, bs, nd);
            chk($sformatf("v%0d_res", i), r, vecs[i].exp);
            chk($sformatf("v%0d_ovfl", i), 32'(o), 32'(vecs[i].eovfl));
            chk($sformatf("v%0d_inv", i), 32'(iv), 32'(vecs[i].einv));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].elat));
            chk($sformatf("v%0d_busy", i), 32'(bs), 32'd1);
            chk($sformatf("v%0d_ndone", i), 32'(nd), 32'd1);
        end

        // start re-pulsed while busy: one done, result unharmed
        conv(1'b1, 32'h3F80_0000, 1'b1, r, o, iv, lat, bs, nd);
        chk("repulse_res", r, 32'h1);
        chk("repulse_lat", 32'(lat), 32'd10);
        chk("repulse_ndone", 32'(nd), 32'd1);
        conv(1'b0, 32'h4F00_0000, 1'b1, r, o, iv, lat, bs, nd);
        chk("repulse_sp_res", r, 32'h7FFF_FFFF);
        chk("repulse_sp_ndone", 32'(nd), 32'd1);

        // start held through done: not accepted in the done cycle
        @(negedge clk);
        fp1 = 32'h3F00_0000;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_busy_a", 32'(busy1), 32'd1);
        @(posedge clk);
        #1;
        chk("hold_done", 32'(done1), 32'd1);
        @(posedge clk);
        #1;
        chk("hold_busy_in_done", 32'(busy1), 32'd0);
        @(posedge clk);
        #1;
        chk("hold_busy_after", 32'(busy1), 32'd1);
        start1 = 1'b0;
        repeat (4) @(posedge clk);

        // reset during SHIFT aborts with outputs cleared
        conv(1'b0, 32'hC2F6_E979, 1'b0, r, o, iv, lat, bs, nd);
        @(negedge clk);
        fp1 = 32'h3F80_0000;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_res", res1, 32'h0);
        chk("rst_mid_flags", {29'b0, busy1, done1, ovfl1}, '0);
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done1) nd++;
        end
        chk("rst_mid_nodone", 32'(nd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        conv(1'b0, 32'hC2F6_E979, 1'b0, r, o, iv, lat, bs, nd);
        chk("post_rst_res", r, 32'hFFFF_FF85);
        chk("post_rst_lat", 32'(lat), 32'd27);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
